// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its pixel-side consumers.
// The generator takes the master view; the renderer / DAC side takes the slave view.
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             enable;
    logic [CNT_W-1:0] x_pos;
    logic [CNT_W-1:0] y_pos;
    logic             display_enable;
    logic             hsync;
    logic             vsync;
    logic             vblank;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  enable,
        output x_pos, y_pos, display_enable, hsync, vsync, vblank, line_start, frame_start
    );

    modport slave (
        output enable,
        input  x_pos, y_pos, display_enable, hsync, vsync, vblank, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a programmable delay line on the timing outputs.
// The delay keeps sync aligned with pixel data from downstream logic that adds latency.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int PIPE_DELAY = 0,
    parameter int CNT_W      = 10
) (
    input  logic              VGA_clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CNT_W < 1 || CNT_W > 30 ||
        H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) ||
        PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_param_check
        $fatal(1, "vga_timing_gen: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Sync fields hold "asserted" flags; the polarity is applied only at the pins.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic vb;
        logic ls;
        logic fs;
    } timing_t;

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    timing_t          w_decode;
    timing_t          r_pipe [0:PIPE_DELAY];

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (!bus.enable) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_x == H_LAST) begin
            r_x <= '0;
            r_y <= (r_y == V_LAST) ? '0 : r_y + 1'b1;
        end else begin
            r_x <= r_x + 1'b1;
        end
    end

    // While disabled the counters sit at (0,0), so the decode must be masked or fs would repeat.
    always_comb begin
        w_decode = '0;
        if (bus.enable) begin
            w_decode.de = (r_x < H_ACT) && (r_y < V_ACT);
            w_decode.hs = (r_x >= HS_BEG) && (r_x < HS_END);
            w_decode.vs = (r_y >= VS_BEG) && (r_y < VS_END);
            w_decode.vb = (r_y >= V_ACT);
            w_decode.ls = (r_x == '0) && (r_y < V_ACT);
            w_decode.fs = (r_x == '0) && (r_y == '0);
        end
    end

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_decode;
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign bus.x_pos          = r_x;
    assign bus.y_pos          = r_y;
    assign bus.display_enable = r_pipe[PIPE_DELAY].de;
    assign bus.hsync          = r_pipe[PIPE_DELAY].hs ? H_POL : ~H_POL;
    assign bus.vsync          = r_pipe[PIPE_DELAY].vs ? V_POL : ~V_POL;
    assign bus.vblank         = r_pipe[PIPE_DELAY].vb;
    assign bus.line_start     = r_pipe[PIPE_DELAY].ls;
    assign bus.frame_start    = r_pipe[PIPE_DELAY].fs;

endmodule
